seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 15 +
 rtl/scan_timer.sv | 31 +++
 rtl/seg_scan.sv | 64 ++++++
 tb/tb_seg_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: constants and helpers shared by the scanner and the hex-digit latch.
package seg_pkg;

    localparam int DIGITS = 4;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF = 4'hF;

    typedef logic [$clog2(DIGITS)-1:0] dig_t;

    function automatic logic [DIGITS-1:0] an_sel(input dig_t d);
        return ~(DIGITS'(1) << d);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot counter cnt and digit index d with slot/frame end strobes.
module scan_timer
    import seg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [$clog2(DIV)-1:0] cnt,
    output dig_t                   d,
    output logic                   frame_end
);

    localparam int CW = $clog2(DIV);

    logic slot_end;

    assign slot_end = cnt == CW'(DIV - 1);
    assign frame_end = slot_end && d == dig_t'(DIGITS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            d <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            d <= slot_end ? d + 1'b1 : d;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 4-digit seven-segment scanner with dead time,
// PWM brightness and frame-synchronous snapshot of the digit patterns.
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV  = 50000,
    parameter int DEAD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGITS*SEG_W-1:0]   seg,
    input  logic [2:0]                bright,
    output logic [DIGITS-1:0]         an,
    output logic [SEG_W-1:0]          seg_o,
    output logic                      frame
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0]             cnt;
    dig_t                      d;
    logic                      frame_end;
    logic [2:0]                p;
    logic [DIGITS*SEG_W-1:0]   snap;
    logic [2:0]                bsnap;
    logic                      pending;
    logic                      load;
    logic                      on;
    logic                      lit;

    scan_timer #(.DIV(DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .d         (d),
        .frame_end (frame_end)
    );

    assign load = pending || frame_end;
    assign on = cnt >= CW'(DEAD);
    assign lit = on && p < bsnap;

    // p is cleared one clock early so it reads 0 on the first on-window clock
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            snap <= '1;
            bsnap <= '0;
            pending <= 1'b1;
            an <= AN_OFF;
            seg_o <= SEG_BLANK;
            frame <= 1'b0;
        end else begin
            p <= (cnt == CW'(DEAD - 1) || p == 3'd6) ? '0 : on ? p + 3'd1 : p;
            pending <= 1'b0;
            frame <= load;
            snap <= load ? seg : snap;
            bsnap <= load ? bright : bsnap;
            an <= lit ? an_sel(d) : AN_OFF;
            seg_o <= lit ? snap[d*SEG_W +: SEG_W] : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed scoreboard bench for seg_scan with DIV=8, DEAD=2.
module tb_seg_scan;

    typedef struct {
        int         d;
        logic [6:0] s;
        int         len;
        int         gap;
    } run_t;

    localparam logic [27:0] SEG_A = {7'h0E, 7'h12, 7'h79, 7'h40};
    localparam logic [27:0] SEG_B = {7'h06, 7'h24, 7'h30, 7'h19};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] seg = SEG_A;
    logic [2:0]  bright = 3'd7;
    logic [3:0]  an;
    logic [6:0]  seg_o;
    logic        frame;

    run_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   mon_off = 1'b1;

    always #5 clk = ~clk;

    seg_scan #(.DIV(8), .DEAD(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg    (seg),
        .bright (bright),
        .an     (an),
        .seg_o  (seg_o),
        .frame  (frame)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic int dig_of(input logic [3:0] a);
        for (int k = 0; k < 4; k++) if (!a[k]) return k;
        return -1;
    endfunction

    // Expected lit runs for one frame: L lit clocks per slot, 8-L blank between slots
    task automatic push_frame(input logic [27:0] s, input int b, input int g0);
        int l;
        run_t e;
        l = b > 6 ? 6 : b;
        if (l == 0) return;
        for (int k = 0; k < 4; k++) begin
            e.d = k;
            e.s = s[7*k +: 7];
            e.len = l;
            e.gap = k == 0 ? g0 : 8 - l;
            q.push_back(e);
        end
    endtask

    task automatic end_run(input run_t cur);
        run_t e;
        chk("run_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("run_digit", 32'(cur.d), 32'(e.d));
            chk("run_seg", 32'(cur.s), 32'(e.s));
            chk("run_len", 32'(cur.len), 32'(e.len));
            if (e.gap >= 0) chk("run_gap", 32'(cur.gap), 32'(e.gap));
        end
    endtask

    // Continuous monitor: one-hot anodes, blanking between digits, run scoreboard
    initial begin
        run_t cur;
        bit in_run = 1'b0;
        int gapc = -1;
        logic [3:0] prev_an = 4'hF;
        logic lit;
        cur = '{d: -1, s: 7'h7F, len: 0, gap: -1};
        forever begin
            @(negedge clk);
            lit = an != 4'hF;
            chk("onehot_an", 32'($onehot0(~an)), 32'd1);
            chk("no_back_to_back", 32'(prev_an != 4'hF && lit && an != prev_an), 32'd0);
            if (!lit) chk("blank_seg", 32'(seg_o), 32'h7F);
            prev_an = an;
            if (mon_off) begin
                in_run = 1'b0;
                gapc = -1;
            end else if (lit) begin
                if (in_run && dig_of(an) == cur.d && seg_o == cur.s) cur.len++;
                else begin
                    if (in_run) end_run(cur);
                    in_run = 1'b1;
                    cur.d = dig_of(an);
                    cur.s = seg_o;
                    cur.len = 1;
                    cur.gap = gapc;
                    gapc = 0;
                end
            end else begin
                if (in_run) begin
                    end_run(cur);
                    in_run = 1'b0;
                    gapc = 0;
                end
                if (gapc >= 0) gapc++;
            end
        end
    end

    task automatic wait_frame(output int n, output int lit);
        n = 0;
        lit = 0;
        do begin
            @(negedge clk);
            n++;
            if (an != 4'hF) lit++;
        end while (!frame && n < 100);
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    initial begin
        int n;
        int lit;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg_o", 32'(seg_o), 32'h7F);
        chk("rst_frame", 32'(frame), 32'd0);
        rst = 1'b0;
        mon_off = 1'b0;
        wait_frame(n, lit);
        chk("first_frame_delay", 32'(n), 32'd1);
        push_frame(SEG_A, 7, -1);
        wait_frame(n, lit);
        chk("frame_period_first", 32'(n), 32'd31);
        push_frame(SEG_A, 7, 2);
        bright = 3'd3;
        wait_frame(n, lit);
        chk("frame_period", 32'(n), 32'd32);
        push_frame(SEG_A, 3, 2);
        bright = 3'd0;
        wait_frame(n, lit);
        chk("frame_period_b3", 32'(n), 32'd32);
        bright = 3'd7;
        wait_frame(n, lit);
        chk("frame_period_off", 32'(n), 32'd32);
        chk("off_lit_clocks", 32'(lit), 32'd0);
        push_frame(SEG_A, 7, -1);
        repeat (10) @(negedge clk);
        seg = SEG_B;
        wait_frame(n, lit);
        chk("frame_after_update", 32'(n), 32'd22);
        push_frame(SEG_B, 7, 2);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        mon_off = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg_o", 32'(seg_o), 32'h7F);
        chk("midrst_frame", 32'(frame), 32'd0);
        rst = 1'b0;
        q.delete();
        mon_off = 1'b0;
        wait_frame(n, lit);
        chk("midrst_first_frame", 32'(n), 32'd1);
        push_frame(SEG_B, 7, -1);
        wait_frame(n, lit);
        chk("midrst_next_frame", 32'(n), 32'd31);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
